// File: rtl/hazard_pkg.sv
// Shared types, state encoding and control-word constants for the
// pipeline hazard controller and its comparator.
package hazard_pkg;
  localparam int REG_ADD_W = 3;
  localparam int CNT_W     = 3;
  localparam int WAIT_W    = 16;
  localparam int STALL_W   = 16;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FLUSH    = 2'b10,
    MEM_WAIT = 2'b11
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                   idex_bubble: 1'b0, pipe_hold: 1'b0};
  localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                   idex_bubble: 1'b1, pipe_hold: 1'b0};
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                   idex_bubble: 1'b1, pipe_hold: 1'b0};
  localparam ctrl_t CTRL_HOLD  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                   idex_bubble: 1'b0, pipe_hold: 1'b1};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the decode instruction reads a register that the load
// in execute has not produced yet. Register 0 is compared like any other.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_ADD_W-1:0] id_src_add,
  input  logic [REG_ADD_W-1:0] id_dst_add,
  input  logic                 id_uses_src,
  input  logic                 id_uses_dst,
  input  logic [REG_ADD_W-1:0] ex_dst_add,
  input  logic                 ex_mem_read,
  output logic                 lu
);
  assign lu = ex_mem_read &
              ((id_uses_src & (ex_dst_add == id_src_add)) |
               (id_uses_dst & (ex_dst_add == id_dst_add)));
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller FSM: load-use bubbles, branch flush, memory-busy freeze,
// stall-cycle counter and sticky memory-timeout flag.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT         = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_ADD_W-1:0] id_src_add,
  input  logic [REG_ADD_W-1:0] id_dst_add,
  input  logic                 id_uses_src,
  input  logic                 id_uses_dst,
  input  logic [REG_ADD_W-1:0] ex_dst_add,
  input  logic                 ex_mem_read,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic                 pipe_hold,
  output logic                 mem_timeout,
  output logic [STALL_W-1:0]   stall_cnt
);
  localparam logic [CNT_W-1:0]  LU_LAST = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FL_LAST = CNT_W'(BRANCH_FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] TMO     = WAIT_W'(MEM_TIMEOUT);

  logic                lu;
  logic                mem_wait;
  ctrl_t               ctrl;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

  hazard_detect u_detect (
    .id_src_add  (id_src_add),
    .id_dst_add  (id_dst_add),
    .id_uses_src (id_uses_src),
    .id_uses_dst (id_uses_dst),
    .ex_dst_add  (ex_dst_add),
    .ex_mem_read (ex_mem_read),
    .lu          (lu)
  );

  assign mem_wait = mem_req & ~mem_ack;

  // Next-state and output decode; overriding hazards act in the same cycle,
  // while each stall/flush/wait state supplies its own outputs otherwise.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    ctrl       = CTRL_IDLE;
    case (state_q)
      MEM_WAIT: begin
        ctrl = CTRL_HOLD;
        if (mem_req && mem_ack) begin
          state_d = RUN;
        end else begin
          wait_cnt_d = sat_inc16(wait_cnt_q);
          timeout_d  = timeout_q | (wait_cnt_d >= TMO);
        end
      end
      default: begin
        if (mem_wait) begin
          ctrl       = CTRL_HOLD;
          state_d    = MEM_WAIT;
          wait_cnt_d = 16'd1;
          timeout_d  = timeout_q | (wait_cnt_d >= TMO);
        end else if (state_q == FLUSH) begin
          ctrl    = CTRL_FLUSH;
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_q == FL_LAST) ? RUN : FLUSH;
        end else if (branch_taken) begin
          ctrl    = CTRL_FLUSH;
          cnt_d   = 3'd1;
          state_d = (BRANCH_FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (state_q == LU_STALL) begin
          ctrl    = CTRL_STALL;
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_q == LU_LAST) ? RUN : LU_STALL;
        end else if (lu) begin
          ctrl    = CTRL_STALL;
          cnt_d   = 3'd1;
          state_d = (LOAD_STALL_CYCLES > 1) ? LU_STALL : RUN;
        end else begin
          state_d = RUN;
        end
      end
    endcase
    // Outputs fall to idle as soon as reset asserts, not at the next edge.
    if (!rst) begin
      ctrl = CTRL_IDLE;
    end else begin
      ctrl = ctrl;
    end
    stall_cnt_d = ctrl.pc_write ? stall_cnt_q : sat_inc16(stall_cnt_q);
  end

  // State, counters and sticky timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      wait_cnt_q  <= 16'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign pipe_hold   = ctrl.pipe_hold;
  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (short and long stall/flush settings)
// share one stimulus and are compared every cycle against a behavioural model.
module tb_hazard_ctrl;
  localparam int TMO = 8;
  localparam logic [4:0] E_IDLE  = 5'b11000;
  localparam logic [4:0] E_STALL = 5'b00010;
  localparam logic [4:0] E_FLUSH = 5'b11110;
  localparam logic [4:0] E_HOLD  = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] id_src_add, id_dst_add, ex_dst_add;
  logic id_uses_src, id_uses_dst, ex_mem_read, branch_taken, mem_req, mem_ack;

  logic a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_pipe_hold, a_mem_timeout;
  logic b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_pipe_hold, b_mem_timeout;
  logic [15:0] a_stall_cnt, b_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .BRANCH_FLUSH_CYCLES(1), .MEM_TIMEOUT(TMO)) u_a (
    .clk(clk), .rst(rst), .id_src_add(id_src_add), .id_dst_add(id_dst_add),
    .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst), .ex_dst_add(ex_dst_add),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ack(mem_ack), .pc_write(a_pc_write), .ifid_write(a_ifid_write),
    .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble), .pipe_hold(a_pipe_hold),
    .mem_timeout(a_mem_timeout), .stall_cnt(a_stall_cnt));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(2), .MEM_TIMEOUT(TMO)) u_b (
    .clk(clk), .rst(rst), .id_src_add(id_src_add), .id_dst_add(id_dst_add),
    .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst), .ex_dst_add(ex_dst_add),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ack(mem_ack), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
    .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .pipe_hold(b_pipe_hold),
    .mem_timeout(b_mem_timeout), .stall_cnt(b_stall_cnt));

  logic [4:0]  ctl [2];
  logic        tmo_o [2];
  logic [15:0] sc [2];
  assign ctl[0]   = {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_pipe_hold};
  assign ctl[1]   = {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_pipe_hold};
  assign tmo_o[0] = a_mem_timeout;
  assign tmo_o[1] = b_mem_timeout;
  assign sc[0]    = a_stall_cnt;
  assign sc[1]    = b_stall_cnt;

  // Model state: remaining bubble/flush cycles, memory-wait bookkeeping.
  int lu_rem [2];
  int fl_rem [2];
  int waited [2];
  int stalls [2];
  bit in_mem [2];
  bit tmo    [2];

  function automatic int p_load(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int p_flush(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic bit model_lu();
    bit hit_src, hit_dst;
    hit_src = id_uses_src && (int'(ex_dst_add) == int'(id_src_add));
    hit_dst = id_uses_dst && (int'(ex_dst_add) == int'(id_dst_add));
    return ex_mem_read && (hit_src || hit_dst);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : compare
    logic [4:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst) begin
          lu_rem[i] = 0; fl_rem[i] = 0; waited[i] = 0;
          stalls[i] = 0; in_mem[i] = 1'b0; tmo[i] = 1'b0;
        end
        check($sformatf("stall_cnt u%0d", i), 32'(sc[i]), 32'(stalls[i]));
        check($sformatf("mem_timeout u%0d", i), 32'(tmo_o[i]), 32'(tmo[i]));
        if (!rst) begin
          e = E_IDLE;
        end else if (in_mem[i]) begin
          e = E_HOLD;
          if (mem_req && mem_ack) in_mem[i] = 1'b0;
          else begin
            waited[i] = (waited[i] < 65535) ? waited[i] + 1 : 65535;
            if (waited[i] >= TMO) tmo[i] = 1'b1;
          end
        end else if (mem_req && !mem_ack) begin
          e = E_HOLD;
          in_mem[i] = 1'b1; waited[i] = 1; lu_rem[i] = 0; fl_rem[i] = 0;
          if (TMO <= 1) tmo[i] = 1'b1;
        end else if (fl_rem[i] > 0) begin
          e = E_FLUSH; fl_rem[i]--;
        end else if (branch_taken) begin
          e = E_FLUSH; fl_rem[i] = p_flush(i) - 1; lu_rem[i] = 0;
        end else if (lu_rem[i] > 0) begin
          e = E_STALL; lu_rem[i]--;
        end else if (model_lu()) begin
          e = E_STALL; lu_rem[i] = p_load(i) - 1;
        end else begin
          e = E_IDLE;
        end
        check($sformatf("ctrl u%0d", i), 32'(ctl[i]), 32'(e));
        if (rst && !e[4]) stalls[i] = (stalls[i] < 65535) ? stalls[i] + 1 : 65535;
      end
    end
  end

  task automatic setin(input logic [2:0] s, input logic [2:0] d, input logic us,
                       input logic ud, input logic [2:0] exd, input logic exr,
                       input logic br, input logic rq, input logic ak);
    id_src_add = s; id_dst_add = d; id_uses_src = us; id_uses_dst = ud;
    ex_dst_add = exd; ex_mem_read = exr; branch_taken = br; mem_req = rq; mem_ack = ak;
  endtask

  // One cycle of stimulus; returns mid-cycle so literal checks see settled outputs.
  task automatic tick(input logic [2:0] s, input logic [2:0] d, input logic us,
                      input logic ud, input logic [2:0] exd, input logic exr,
                      input logic br, input logic rq, input logic ak);
    @(posedge clk); #1;
    setin(s, d, us, ud, exd, exr, br, rq, ak);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    setin(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin : stim
    bit [3:0] exp_b;
    rst = 1'b1;
    setin(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("reset pc_write", 32'(a_pc_write), 32'd1);
    check("reset stall_cnt", 32'(a_stall_cnt), 32'd0);
    check("reset mem_timeout", 32'(a_mem_timeout), 32'd0);

    // load r3 in EX, add r3 r1 in ID
    tick(3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu pc_write", 32'(a_pc_write), 32'd0);
    check("lu ifid_write", 32'(a_ifid_write), 32'd0);
    check("lu idex_bubble", 32'(a_idex_bubble), 32'd1);
    idle(1);
    check("after lu idle", 32'({a_pc_write, a_ifid_write, a_idex_bubble}), 32'b110);
    check("after lu stall_cnt", 32'(a_stall_cnt), 32'd1);
    idle(3);

    // load r2, ID reads r5/r4: no hazard
    tick(3'd5, 3'd4, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    check("no lu a", 32'(a_idex_bubble), 32'd0);
    check("no lu b", 32'(b_pc_write), 32'd1);
    // hazard on r2: long-stall instance bubbles for exactly 3 cycles
    exp_b = 4'b0111;
    tick(3'd2, 3'd4, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    check("b bubble 0", 32'(b_idex_bubble), 32'(exp_b[0]));
    for (int k = 1; k < 4; k++) begin
      idle(1);
      check($sformatf("b bubble %0d", k), 32'(b_idex_bubble), 32'(exp_b[k]));
    end
    // register 0 compares normally; unused source does not match
    tick(3'd0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("r0 lu", 32'(a_idex_bubble), 32'd1);
    tick(3'd0, 3'd5, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("unused src", 32'(a_idex_bubble), 32'd0);
    idle(3);

    // branch and load-use together: branch wins
    tick(3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    check("br+lu a", 32'({a_pc_write, a_ifid_flush, a_idex_bubble}), 32'b111);
    check("br+lu b flush", 32'(b_ifid_flush), 32'd1);
    idle(1);
    check("flush2 b", 32'(b_ifid_flush), 32'd1);
    check("flush2 a", 32'(a_ifid_flush), 32'd0);
    idle(1);
    check("flush3 b", 32'(b_ifid_flush), 32'd0);

    // branch during a multi-cycle load stall
    tick(3'd1, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lu->br b", 32'({b_pc_write, b_ifid_flush}), 32'b11);
    idle(3);

    // memory busy 4 cycles with a pending load-use
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick(3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
      check($sformatf("mem hold %0d", k), 32'(a_pipe_hold), 32'd1);
    end
    tick(3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    check("mem hold ack", 32'(a_pipe_hold), 32'd1);
    tick(3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post mem lu", 32'({a_pc_write, a_idex_bubble, a_pipe_hold}), 32'b010);
    idle(1);
    check("mem stall_cnt", 32'(a_stall_cnt), 32'd5);
    idle(2);

    // timeout after 8 wait cycles, sticky past ack
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (k == 7) check("tmo before", 32'(a_mem_timeout), 32'd0);
      if (k == 8) check("tmo at 8", 32'(a_mem_timeout), 32'd1);
    end
    tick(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ack w/o req", 32'(a_pipe_hold), 32'd1);
    tick(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ack hold", 32'(a_pipe_hold), 32'd1);
    idle(1);
    check("released hold", 32'(a_pipe_hold), 32'd0);
    check("tmo sticky", 32'(a_mem_timeout), 32'd1);

    // asynchronous reset in the middle of a memory wait
    tick(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check("async idle", 32'({a_pc_write, a_ifid_write, a_pipe_hold}), 32'b110);
    check("async stall_cnt", 32'(a_stall_cnt), 32'd0);
    check("async tmo", 32'(a_mem_timeout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    setin(3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    check("run after rst", 32'({a_pc_write, a_idex_bubble}), 32'b01);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
